// File: rtl/note_lane_renderer.sv
// Rhythm-game note field: four falling-note lanes, hit judgement and
// registered per-pixel colour for the VGA DAC.
module note_lane_renderer #(
  parameter int SLOTS   = 8,
  parameter int SPEED   = 4,
  parameter int LANE_X0 = 160,
  parameter int LANE_W  = 80,
  parameter int NOTE_H  = 16,
  parameter int HIT_Y   = 400,
  parameter int HIT_WIN = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] xPixel,
  input  logic [9:0] yPixel,
  input  logic       active_pixels,
  input  logic       frame_done,
  input  logic       spawn_valid,
  input  logic [1:0] spawn_lane,
  output logic       spawn_ready,
  input  logic [3:0] key_press,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic [1:0] hit_lane,
  output logic [4:0] notes_active,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue
);

  localparam logic [10:0] WIN_LO = 11'(HIT_Y - HIT_WIN);
  localparam logic [10:0] WIN_HI = 11'(HIT_Y + HIT_WIN);
  localparam logic [10:0] Y_END  = 11'd480;

  logic [SLOTS-1:0] valid_q, valid_d;
  logic [1:0]       lane_q [SLOTS];
  logic [1:0]       lane_d [SLOTS];
  logic [9:0]       y_q [SLOTS];
  logic [9:0]       y_d [SLOTS];

  logic        fd_q, tick, take;
  logic        hit_q, hit_d;
  logic        miss_q, miss_d;
  logic [1:0]  hl_q, hl_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [23:0] rgb_q, rgb_d;

  logic [SLOTS-1:0] hit_sel;
  logic             found, placed;
  logic [10:0]      ny;

  logic [3:0]  in_lane;
  logic        note_px;
  logic [23:0] note_col;
  logic [10:0] x11, y11;

  function automatic logic [23:0] lane_rgb(input logic [1:0] l);
    logic [23:0] c;
    case (l)
      2'd0:    c = 24'hFF0000;
      2'd1:    c = 24'h00FF00;
      2'd2:    c = 24'h0000FF;
      default: c = 24'hFFFF00;
    endcase
    return c;
  endfunction

  assign tick        = frame_done & ~fd_q;
  assign spawn_ready = ~&valid_q;
  assign take        = spawn_valid & spawn_ready;

  // Lower lanes are scanned first so the highest hit lane lands last.
  always_comb begin
    hit_sel = '0;
    hit_d   = 1'b0;
    hl_d    = hl_q;
    found   = 1'b0;
    for (int l = 0; l < 4; l++) begin
      found = 1'b0;
      for (int s = 0; s < SLOTS; s++) begin
        if (key_press[l] && !found && valid_q[s] &&
            lane_q[s] == 2'(l) &&
            {1'b0, y_q[s]} >= WIN_LO &&
            {1'b0, y_q[s]} <= WIN_HI) begin
          hit_sel[s] = 1'b1;
          found      = 1'b1;
          hit_d      = 1'b1;
          hl_d       = 2'(l);
        end
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    lane_d  = lane_q;
    y_d     = y_q;
    miss_d  = 1'b0;
    placed  = 1'b0;
    ny      = '0;
    cnt_d   = '0;
    for (int s = 0; s < SLOTS; s++) begin
      ny = {1'b0, y_q[s]} + 11'(SPEED);
      if (hit_sel[s]) begin
        valid_d[s] = 1'b0;
      end else if (valid_q[s] && tick) begin
        if (ny >= Y_END) begin
          valid_d[s] = 1'b0;
          miss_d     = 1'b1;
        end else begin
          y_d[s] = ny[9:0];
        end
      end
    end
    // Only slots free at cycle start take a spawn.
    for (int s = 0; s < SLOTS; s++) begin
      if (take && !placed && !valid_q[s]) begin
        valid_d[s] = 1'b1;
        lane_d[s]  = spawn_lane;
        y_d[s]     = '0;
        placed     = 1'b1;
      end
    end
    for (int s = 0; s < SLOTS; s++) begin
      cnt_d = cnt_d + 5'(valid_d[s]);
    end
  end

  always_comb begin
    x11      = {1'b0, xPixel};
    y11      = {1'b0, yPixel};
    note_px  = 1'b0;
    note_col = '0;
    rgb_d    = '0;
    for (int l = 0; l < 4; l++) begin
      in_lane[l] = x11 >= 11'(LANE_X0 + l * LANE_W) &&
                   x11 <= 11'(LANE_X0 + (l + 1) * LANE_W - 1);
    end
    for (int s = 0; s < SLOTS; s++) begin
      if (valid_q[s] && in_lane[lane_q[s]] &&
          y11 >= {1'b0, y_q[s]} &&
          y11 < {1'b0, y_q[s]} + 11'(NOTE_H)) begin
        note_px  = 1'b1;
        note_col = lane_rgb(lane_q[s]);
      end
    end
    if (active_pixels) begin
      if (|in_lane && yPixel == 10'(HIT_Y)) begin
        rgb_d = 24'hFFFFFF;
      end else if (note_px) begin
        rgb_d = note_col;
      end else if (|in_lane) begin
        rgb_d = 24'h202020;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      lane_q  <= '{default: '0};
      y_q     <= '{default: '0};
      fd_q    <= 1'b1;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      hl_q    <= '0;
      cnt_q   <= '0;
      rgb_q   <= '0;
    end else begin
      valid_q <= valid_d;
      lane_q  <= lane_d;
      y_q     <= y_d;
      fd_q    <= frame_done;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      hl_q    <= hl_d;
      cnt_q   <= cnt_d;
      rgb_q   <= rgb_d;
    end
  end

  assign hit_pulse    = hit_q;
  assign miss_pulse   = miss_q;
  assign hit_lane     = hl_q;
  assign notes_active = cnt_q;
  assign red          = rgb_q[23:16];
  assign green        = rgb_q[15:8];
  assign blue         = rgb_q[7:0];

endmodule

// File: tb/tb_note_lane_renderer.sv
// Scoreboard bench for note_lane_renderer: directed scenarios then random
// traffic, checked against a per-cycle note-list model.
module tb_note_lane_renderer;

  localparam int NS = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] xPixel = '0;
  logic [9:0] yPixel = '0;
  logic       active_pixels = 1'b0;
  logic       frame_done = 1'b0;
  logic       spawn_valid = 1'b0;
  logic [1:0] spawn_lane = '0;
  logic       spawn_ready;
  logic [3:0] key_press = '0;
  logic       hit_pulse, miss_pulse;
  logic [1:0] hit_lane;
  logic [4:0] notes_active;
  logic [7:0] red, green, blue;

  typedef struct packed {
    logic        hp;
    logic        mp;
    logic [1:0]  hl;
    logic [4:0]  cnt;
    logic        rdy;
    logic [23:0] rgb;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;

  int m_valid [NS];
  int m_lane [NS];
  int m_y [NS];
  int m_prev_fd = 1;
  int m_hl = 0;

  note_lane_renderer dut (
    .clk(clk), .rst(rst),
    .xPixel(xPixel), .yPixel(yPixel),
    .active_pixels(active_pixels),
    .frame_done(frame_done),
    .spawn_valid(spawn_valid),
    .spawn_lane(spawn_lane),
    .spawn_ready(spawn_ready),
    .key_press(key_press),
    .hit_pulse(hit_pulse),
    .miss_pulse(miss_pulse),
    .hit_lane(hit_lane),
    .notes_active(notes_active),
    .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  function automatic int lane_of_x(input int x);
    if (x >= 160 && x < 480) return (x - 160) / 80;
    return -1;
  endfunction

  function automatic logic [23:0] colour_of(input int l);
    case (l)
      0: return 24'hFF0000;
      1: return 24'h00FF00;
      2: return 24'h0000FF;
      default: return 24'hFFFF00;
    endcase
  endfunction

  task automatic model(input logic r, input logic f, input logic sv,
                       input logic [1:0] sl, input logic [3:0] kp,
                       input int x, input int y, input logic act,
                       output exp_t e);
    int ln, cnt;
    bit ready0, tick, hit, miss, placed;
    bit hitmark [NS];
    bit free0 [NS];
    e = '0;
    if (r) begin
      for (int s = 0; s < NS; s++) m_valid[s] = 0;
      m_prev_fd = 1;
      m_hl = 0;
      e.rdy = 1'b1;
      return;
    end
    ln = lane_of_x(x);
    if (act && ln >= 0) begin
      if (y == 400) e.rgb = 24'hFFFFFF;
      else begin
        e.rgb = 24'h202020;
        for (int s = 0; s < NS; s++)
          if (m_valid[s] != 0 && m_lane[s] == ln &&
              y >= m_y[s] && y < m_y[s] + 16)
            e.rgb = colour_of(ln);
      end
    end
    tick = f && m_prev_fd == 0;
    m_prev_fd = f ? 1 : 0;
    ready0 = 0;
    for (int s = 0; s < NS; s++) begin
      free0[s] = m_valid[s] == 0;
      if (free0[s]) ready0 = 1;
      hitmark[s] = 0;
    end
    hit = 0;
    for (int l = 0; l < 4; l++) begin
      if (kp[l]) begin
        for (int s = 0; s < NS; s++) begin
          if (m_valid[s] != 0 && m_lane[s] == l &&
              m_y[s] >= 400 - 12 && m_y[s] <= 400 + 12) begin
            hitmark[s] = 1;
            hit = 1;
            m_hl = l;
            break;
          end
        end
      end
    end
    miss = 0;
    for (int s = 0; s < NS; s++) begin
      if (hitmark[s]) m_valid[s] = 0;
      else if (m_valid[s] != 0 && tick) begin
        m_y[s] = m_y[s] + 4;
        if (m_y[s] >= 480) begin
          m_valid[s] = 0;
          miss = 1;
        end
      end
    end
    placed = 0;
    if (sv && ready0) begin
      for (int s = 0; s < NS && !placed; s++) begin
        if (free0[s]) begin
          m_valid[s] = 1;
          m_lane[s] = int'(sl);
          m_y[s] = 0;
          placed = 1;
        end
      end
    end
    cnt = 0;
    for (int s = 0; s < NS; s++) if (m_valid[s] != 0) cnt++;
    e.hp = hit;
    e.mp = miss;
    e.hl = 2'(m_hl);
    e.cnt = 5'(cnt);
    e.rdy = cnt < NS;
  endtask

  task automatic drive(input logic r, input logic f, input logic sv,
                       input logic [1:0] sl, input logic [3:0] kp,
                       input int x, input int y, input logic act);
    exp_t e;
    @(negedge clk);
    rst = r;
    frame_done = f;
    spawn_valid = sv;
    spawn_lane = sl;
    key_press = kp;
    xPixel = 10'(x);
    yPixel = 10'(y);
    active_pixels = act;
    model(r, f, sv, sl, kp, x, y, act, e);
    sbq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 2'd0, 4'd0, 0, 0, 0);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 2'd0, 4'd0, 0, 0, 0);
    drive(1, 0, 0, 2'd0, 4'd0, 0, 0, 0);
    idle(1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 1, 0, 2'd0, 4'd0, 0, 0, 0);
      drive(0, 0, 0, 2'd0, 4'd0, 0, 0, 0);
    end
  endtask

  task automatic spawn(input logic [1:0] l);
    drive(0, 0, 1, l, 4'd0, 0, 0, 0);
  endtask

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", n, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("hit_pulse", 32'(hit_pulse), 32'(e.hp));
        chk("miss_pulse", 32'(miss_pulse), 32'(e.mp));
        chk("hit_lane", 32'(hit_lane), 32'(e.hl));
        chk("notes_active", 32'(notes_active), 32'(e.cnt));
        chk("spawn_ready", 32'(spawn_ready), 32'(e.rdy));
        chk("rgb", 32'({red, green, blue}), 32'(e.rgb));
      end
    end
  end

  initial begin : stim
    logic r, f, sv, act;
    logic [1:0] sl;
    logic [3:0] kp;
    // reset, single spawn, pixel on lane 2 note
    do_reset();
    spawn(2'd2);
    drive(0, 0, 0, 2'd0, 4'd0, 360, 8, 1);
    drive(0, 0, 0, 2'd0, 4'd0, 400, 8, 1);
    idle(1);
    // fill all slots, ninth request ignored
    do_reset();
    for (int i = 0; i < 9; i++) spawn(2'(i));
    idle(2);
    // hit at y=400 in lane 1
    do_reset();
    spawn(2'd1);
    ticks(100);
    drive(0, 0, 0, 2'd0, 4'b0010, 0, 0, 0);
    idle(2);
    // leave the screen: 476 -> 480
    do_reset();
    spawn(2'd3);
    ticks(119);
    ticks(3);
    // press outside the window
    do_reset();
    spawn(2'd0);
    ticks(95);
    drive(0, 0, 0, 2'd0, 4'b0001, 0, 0, 0);
    idle(1);
    // hit and tick together at y=412, then pixel corners
    do_reset();
    spawn(2'd2);
    ticks(103);
    drive(0, 1, 0, 2'd0, 4'b0100, 0, 0, 0);
    drive(0, 0, 0, 2'd0, 4'd0, 0, 0, 1);
    drive(0, 0, 0, 2'd0, 4'd0, 170, 400, 1);
    drive(0, 0, 0, 2'd0, 4'd0, 170, 400, 0);
    // mid-frame reset with notes live
    spawn(2'd1);
    drive(1, 0, 0, 2'd0, 4'd0, 200, 2, 1);
    drive(0, 0, 0, 2'd0, 4'd0, 200, 2, 1);
    // random traffic
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      r = $urandom_range(0, 1499) == 0;
      f = $urandom_range(0, 1) == 1;
      sv = $urandom_range(0, 5) == 0;
      sl = 2'($urandom_range(0, 3));
      kp = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      act = $urandom_range(0, 7) != 0;
      drive(r, f, sv, sl, kp, int'($urandom_range(120, 520)),
            int'($urandom_range(0, 479)), act);
    end
    idle(1);
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
